// File: rtl/sub_repeat_div_pkg.sv
// Shared types and helpers for the restoring shift-subtract divider.
// Used by sub_repeat_divider; the signed path (SUB_REPEAT_DIV_SIGNED_EN) relies on twos_mag.
package sub_repeat_div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

    // Two's-complement magnitude (or negation) of a zero-extended value; callers keep the low WIDTH bits.
    function automatic logic [63:0] twos_mag(input logic [63:0] value, input logic neg);
        return neg ? (~value + 64'd1) : value;
    endfunction

endpackage

// File: rtl/sub_repeat_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module sub_repeat_div_step #(
    parameter int WIDTH = 8
) (
    // The remainder entering a step is always below 2^(WIDTH-1), so its top bit is never needed.
    input  logic [WIDTH-2:0] rem_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted = {rem_in, q_msb};
        trial   = {1'b0, shifted} - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted;
    end

endmodule

// File: rtl/sub_repeat_divider.sv
// Sequential restoring divider with valid/ready handshakes, one quotient bit per clock.
// Define SUB_REPEAT_DIV_SIGNED_EN for two's-complement operands (truncating division, overflow flag).
module sub_repeat_divider
    import sub_repeat_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_dbz,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quot_q, rem_q, dsr_q;
    logic             dbz_q;
    logic [WIDTH-1:0] step_rem, quot_step;
    logic             step_bit;
    logic [WIDTH-1:0] load_quot, load_dsr, fin_quot, fin_rem;

    sub_repeat_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q[WIDTH-2:0]),
        .q_msb   (quot_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    assign quot_step = {quot_q[WIDTH-2:0], step_bit};

`ifdef SUB_REPEAT_DIV_SIGNED_EN
    logic neg_quot, neg_rem, ovf_q;

    // Magnitudes go through the unsigned datapath; signs are reapplied on the final step.
    always_comb begin
        load_quot = WIDTH'(twos_mag(64'(i_dividend), i_dividend[WIDTH-1]));
        load_dsr  = WIDTH'(twos_mag(64'(i_divisor), i_divisor[WIDTH-1]));
        fin_quot  = WIDTH'(twos_mag(64'(quot_step), neg_quot));
        fin_rem   = WIDTH'(twos_mag(64'(step_rem), neg_rem));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (state == S_IDLE && i_valid) begin
            neg_quot <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            neg_rem  <= i_dividend[WIDTH-1];
            ovf_q    <= (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (i_divisor == '1);
        end
    end

    assign o_ovf = ovf_q;
`else
    always_comb begin
        load_quot = i_dividend;
        load_dsr  = i_divisor;
        fin_quot  = quot_step;
        fin_rem   = step_rem;
    end

    assign o_ovf = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = (i_divisor == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (cnt == '0) state_next = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt    <= '0;
            dbz_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (i_valid) begin
                    cnt   <= CNT_W'(WIDTH - 1);
                    dsr_q <= load_dsr;
                    if (i_divisor == '0) begin
                        quot_q <= '1;
                        rem_q  <= i_dividend;
                        dbz_q  <= 1'b1;
                    end else begin
                        quot_q <= load_quot;
                        rem_q  <= '0;
                        dbz_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt    <= cnt - CNT_W'(1);
                    quot_q <= (cnt == '0) ? fin_quot : quot_step;
                    rem_q  <= (cnt == '0) ? fin_rem  : step_rem;
                end
                default: ;
            endcase
        end
    end

    assign o_quot = quot_q;
    assign o_rem  = rem_q;
    assign o_dbz  = dbz_q;

endmodule

// File: tb/tb_sub_repeat_divider.sv
// Self-checking bench for sub_repeat_divider (WIDTH=8); signed cases run when SUB_REPEAT_DIV_SIGNED_EN is defined.
module tb_sub_repeat_divider;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
    logic         o_ready, o_valid, o_dbz, o_ovf, o_busy;
    logic [W-1:0] o_quot, o_rem;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    sub_repeat_divider #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_quot     (o_quot),
        .o_rem      (o_rem),
        .o_dbz      (o_dbz),
        .o_ovf      (o_ovf),
        .o_busy     (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; signed mode truncates toward zero like SV '/' and '%'.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output logic ovf);
        int sa, sb;
        dbz = 1'b0;
        ovf = 1'b0;
`ifdef SUB_REPEAT_DIV_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1;
        end else if (sa == -(1 << (W-1)) && sb == -1) begin
            q = W'(sa); r = '0; ovf = 1'b1;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb);
        end
`else
        sa = int'(a);
        sb = int'(b);
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb);
        end
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_quot"},  32'(o_quot),  32'd0);
        chk({tag, "_rem"},   32'(o_rem),   32'd0);
        chk({tag, "_dbz"},   32'(o_dbz),   32'd0);
        chk({tag, "_ovf"},   32'(o_ovf),   32'd0);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
    endtask

    // One full transaction: accept, bounded wait for o_valid, optional stall with ignored requests, handshake.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int unsigned hold);
        logic [W-1:0] eq, er;
        logic         edbz, eovf;
        int unsigned  edges;
        bit           busy_ok;
        model(a, b, eq, er, edbz, eovf);
        @(negedge i_clk);
        chk({tag, "_ready_in"}, 32'(o_ready), 32'd1);
        i_valid    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        @(posedge i_clk);
        #1;
        i_valid    = 1'b0;
        i_dividend = W'($urandom);
        i_divisor  = W'($urandom);
        edges   = 0;
        busy_ok = 1'b1;
        @(negedge i_clk);
        while (!o_valid && edges < 2*W + 4) begin
            if (!o_busy) busy_ok = 1'b0;
            @(negedge i_clk);
            edges++;
        end
        // Edges after the accept edge until o_valid is seen: the divide-by-zero result appears at the accept edge.
        chk({tag, "_latency"}, 32'(edges), (b == 0) ? 32'd0 : 32'(W));
        chk({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
        chk({tag, "_busy_done"}, 32'(o_busy), 32'd0);
        chk({tag, "_quot"}, 32'(o_quot), 32'(eq));
        chk({tag, "_rem"},  32'(o_rem),  32'(er));
        chk({tag, "_dbz"},  32'(o_dbz),  32'(edbz));
        chk({tag, "_ovf"},  32'(o_ovf),  32'(eovf));
        for (int unsigned i = 0; i < hold; i++) begin
            i_valid    = 1'b1;
            i_dividend = W'($urandom);
            i_divisor  = W'($urandom);
            @(negedge i_clk);
            chk({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(o_ready), 32'd0);
            chk({tag, "_hold_quot"},  32'(o_quot),  32'(eq));
            chk({tag, "_hold_rem"},   32'(o_rem),   32'(er));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_post_quot"},  32'(o_quot),  32'(eq));
        chk({tag, "_post_rem"},   32'(o_rem),   32'(er));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           seen_valid;

        #12;
        check_reset_outputs("por");
        @(negedge i_clk);
        i_rst = 1'b0;

        run_div("t1_100_7", 8'd100, 8'd7, 0);
        run_div("t2_200_0", 8'd200, 8'd0, 0);
        run_div("t3_55_5",  8'd55,  8'd5, 5);
        run_div("t3_ff_ff", 8'hFF,  8'hFF, 0);

        // Reset three cycles into RUN must abort with no result.
        @(negedge i_clk);
        i_valid = 1'b1; i_dividend = 8'd100; i_divisor = 8'd7;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("t4_busy_before_rst", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        #1;
        check_reset_outputs("t4_rst");
        @(negedge i_clk);
        i_rst = 1'b0;
        seen_valid = 1'b0;
        for (int unsigned i = 0; i < 2*W; i++) begin
            @(negedge i_clk);
            if (o_valid) seen_valid = 1'b1;
        end
        chk("t4_no_valid", 32'(seen_valid), 32'd0);
        run_div("t4_9_3", 8'd9, 8'd3, 0);

        run_div("t5_7_9",   8'd7,   8'd9, 1);
        run_div("t5_255_1", 8'd255, 8'd1, 0);

`ifdef SUB_REPEAT_DIV_SIGNED_EN
        run_div("t6_m100_7",  8'h9C, 8'd7,  0);
        run_div("t6_m128_m1", 8'h80, 8'hFF, 0);
        run_div("t6_100_m7",  8'd100, 8'hF9, 0);
`endif

        for (int unsigned n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_div("rnd", ra, rb, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
